// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared constants and helpers for the synchronous instruction
//               memory: NOP fill word, default widths, byte-address to word
//               index conversion and byte-enable merge.
//               Helpers work on the widest supported operands; callers
//               zero-extend inputs and truncate results to their own width.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    localparam int          INST_W = 32;
    localparam int          ADDR_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0013;   // addi x0,x0,0

    localparam int c_MAX_ADDR_W = 64;
    localparam int c_MAX_DATA_W = 256;
    localparam int c_MAX_BE_W   = c_MAX_DATA_W / 8;

    // Word index of a byte address; the two low bits select a byte in a word.
    function automatic logic [c_MAX_ADDR_W-1:0] word_idx(
        input logic [c_MAX_ADDR_W-1:0] addr
    );
        return addr >> 2;
    endfunction

    // Replace each byte lane of old_w whose enable is set with the lane of new_w.
    function automatic logic [c_MAX_DATA_W-1:0] merge_be(
        input logic [c_MAX_DATA_W-1:0] old_w,
        input logic [c_MAX_DATA_W-1:0] new_w,
        input logic [c_MAX_BE_W-1:0]   be
    );
        logic [c_MAX_DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < c_MAX_BE_W; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_w[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_sync_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_sync_if
// Description : Fetch request/response port plus loader write port of the
//               instruction memory.
//               master : fetch/loader side (drives req, addr, stall, flush,
//                        wen, wbe, waddr, wdata)
//               slave  : memory side (drives if_ready, if_valid, if_rdata,
//                        if_pc, if_err)
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_sync_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_stall;
    logic                  if_flush;
    logic                  if_ready;
    logic                  if_valid;
    logic [DATA_W-1:0]     if_rdata;
    logic [ADDR_W-1:0]     if_pc;
    logic                  if_err;
    logic                  wen;       // active-low
    logic [DATA_W/8-1:0]   wbe;
    logic [ADDR_W-1:0]     waddr;
    logic [DATA_W-1:0]     wdata;

    modport master (
        output if_req, if_addr, if_stall, if_flush, wen, wbe, waddr, wdata,
        input  if_ready, if_valid, if_rdata, if_pc, if_err
    );

    modport slave (
        input  if_req, if_addr, if_stall, if_flush, wen, wbe, waddr, wdata,
        output if_ready, if_valid, if_rdata, if_pc, if_err
    );

endinterface
`default_nettype wire

// File: rtl/imem_bank.sv
`default_nettype none
// ============================================================================
// Module      : imem_bank
// Description : Word-addressed storage array with byte-enable write and
//               combinational read by index. Every word starts as NOP; reset
//               does not touch the contents.
// Ports       : clk        - clock
//               i_wr_en    - write strobe (index already range-checked)
//               i_wr_idx   - word index to write
//               i_wr_be    - byte-lane enables
//               i_wr_data  - write data
//               i_rd_idx   - word index to read
//               o_rd_data  - contents at i_rd_idx (pre-write value)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_bank #(
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 4096,
    parameter int                IDX_W  = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] NOP    = DATA_W'(32'h0000_0013)
) (
    input  logic                 clk,
    input  logic                 i_wr_en,
    input  logic [IDX_W-1:0]     i_wr_idx,
    input  logic [DATA_W/8-1:0]  i_wr_be,
    input  logic [DATA_W-1:0]    i_wr_data,
    input  logic [IDX_W-1:0]     i_rd_idx,
    output logic [DATA_W-1:0]    o_rd_data
);
    import imem_pkg::*;

    // Declaration initialiser gives the NOP fill for simulation and FPGA
    // bitstream init.
    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: NOP};
    logic [DATA_W-1:0] w_wr_merged;

    assign w_wr_merged = DATA_W'(merge_be(c_MAX_DATA_W'(r_mem[i_wr_idx]),
                                          c_MAX_DATA_W'(i_wr_data),
                                          c_MAX_BE_W'(i_wr_be)));

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= w_wr_merged;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/imem_sync.sv
`default_nettype none
// ============================================================================
// Module      : imem_sync
// Description : Synchronous-read instruction memory for the fetch stage.
//               One-cycle registered response with stall hold, flush,
//               misalignment and range error reporting, and a byte-enable
//               loader write port.
// Ports       : clk, rst (synchronous, active-high)
//               bus (imem_sync_if.slave) - fetch request/response and
//                                          loader write signals
// Config      : IMEM_BYPASS_EN - when defined, a write to the word being
//               fetched in the same cycle is forwarded into if_rdata;
//               otherwise the fetch returns the pre-write contents.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_sync #(
    parameter int                ADDR_W = 32,
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 4096,
    parameter logic [DATA_W-1:0] NOP    = DATA_W'(imem_pkg::NOP)
) (
    input  logic        clk,
    input  logic        rst,
    imem_sync_if.slave  bus
);
    import imem_pkg::*;

    localparam int c_IDX_W = $clog2(DEPTH);

    logic [c_MAX_ADDR_W-1:0] w_rd_idx_full;
    logic [c_MAX_ADDR_W-1:0] w_wr_idx_full;
    logic                    w_rd_err;
    logic                    w_accept;
    logic                    w_wr_en;
    logic [DATA_W-1:0]       w_bank_rdata;
    logic [DATA_W-1:0]       w_rd_word;

    logic                    r_valid;
    logic [DATA_W-1:0]       r_rdata;
    logic [ADDR_W-1:0]       r_pc;
    logic                    r_err;

    assign w_rd_idx_full = word_idx(c_MAX_ADDR_W'(bus.if_addr));
    assign w_wr_idx_full = word_idx(c_MAX_ADDR_W'(bus.waddr));

    // Range check uses the full index so out-of-range addresses never alias
    // onto a low word.
    assign w_rd_err = (bus.if_addr[1:0] != 2'b00) ||
                      (w_rd_idx_full >= c_MAX_ADDR_W'(DEPTH));
    assign w_accept = bus.if_req && !bus.if_stall;
    assign w_wr_en  = !bus.wen && (w_wr_idx_full < c_MAX_ADDR_W'(DEPTH));

    imem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (c_IDX_W),
        .NOP    (NOP)
    ) u_bank (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_wr_idx_full[c_IDX_W-1:0]),
        .i_wr_be   (bus.wbe),
        .i_wr_data (bus.wdata),
        .i_rd_idx  (w_rd_idx_full[c_IDX_W-1:0]),
        .o_rd_data (w_bank_rdata)
    );

`ifdef IMEM_BYPASS_EN
    logic w_fwd_hit;
    assign w_fwd_hit = w_wr_en && (w_wr_idx_full == w_rd_idx_full);
    assign w_rd_word = w_fwd_hit
                     ? DATA_W'(merge_be(c_MAX_DATA_W'(w_bank_rdata),
                                        c_MAX_DATA_W'(bus.wdata),
                                        c_MAX_BE_W'(bus.wbe)))
                     : w_bank_rdata;
`else
    assign w_rd_word = w_bank_rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_rdata <= NOP;
            r_pc    <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            // An accepted request also covers the flush case: redirect wins.
            r_valid <= 1'b1;
            r_pc    <= bus.if_addr;
            r_err   <= w_rd_err;
            r_rdata <= w_rd_err ? NOP : w_rd_word;
        end else if (!bus.if_stall || bus.if_flush) begin
            // Idle cycle, or flush while stalled: drop valid, hold payload.
            r_valid <= 1'b0;
        end
    end

    assign bus.if_ready = !bus.if_stall;
    assign bus.if_valid = r_valid;
    assign bus.if_rdata = r_rdata;
    assign bus.if_pc    = r_pc;
    assign bus.if_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_sync
// Description : Self-checking bench for imem_sync. A driver applies directed
//               then random cycles on the falling edge and pushes the
//               expected post-edge outputs from a behavioural model; a
//               monitor pops and compares just after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_sync;

    localparam int          ADDR_W = 32;
    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 256;
    localparam logic [31:0] c_NOP  = 32'h0000_0013;

    typedef struct {
        logic        ready;
        logic        valid;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    imem_sync_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_sync #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NOP    (c_NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_mem [DEPTH];
    exp_t        m_out;
    exp_t        exp_q [$];
    int          n_cmp   = 0;
    int          n_bad   = 0;
    bit          started = 1'b0;
    bit          done    = 1'b0;

    function automatic logic [31:0] lanes(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic cycle(input logic        r,
                         input logic        req,
                         input logic [31:0] addr,
                         input logic        stall,
                         input logic        flush,
                         input logic        we,
                         input logic [3:0]  be,
                         input logic [31:0] wa,
                         input logic [31:0] wd);
        longint unsigned ridx, widx;
        exp_t e;
        @(negedge clk);
        rst          = r;
        bus.if_req   = req;
        bus.if_addr  = addr;
        bus.if_stall = stall;
        bus.if_flush = flush;
        bus.wen      = ~we;
        bus.wbe      = be;
        bus.waddr    = wa;
        bus.wdata    = wd;

        ridx = longint'(addr) / 4;
        widx = longint'(wa) / 4;
        if (r) begin
            m_out.valid = 1'b0; m_out.rdata = c_NOP; m_out.pc = '0; m_out.err = 1'b0;
        end else if (req && !stall) begin
            m_out.valid = 1'b1;
            m_out.pc    = addr;
            if ((addr % 4) != 0 || ridx >= DEPTH) begin
                m_out.err = 1'b1; m_out.rdata = c_NOP;
            end else begin
                m_out.err   = 1'b0;
                m_out.rdata = m_mem[ridx];
`ifdef IMEM_BYPASS_EN
                if (we && widx == ridx) m_out.rdata = lanes(m_mem[ridx], wd, be);
`endif
            end
        end else if (!stall || flush) begin
            m_out.valid = 1'b0;
        end
        if (we && widx < DEPTH) m_mem[widx] = lanes(m_mem[widx], wd, be);

        e       = m_out;
        e.ready = !stall;
        exp_q.push_back(e);
        started = 1'b1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    endtask
    task automatic rd(input logic [31:0] a);
        cycle(0, 1, a, 0, 0, 0, 4'h0, 0, 0);
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        cycle(0, 0, 0, 0, 0, 1, be, a, d);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (started && !done) begin
                if (exp_q.size() == 0) begin
                    chk("queue_underrun", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("if_ready", 32'(bus.if_ready), 32'(e.ready));
                    chk("if_valid", 32'(bus.if_valid), 32'(e.valid));
                    chk("if_rdata", bus.if_rdata, e.rdata);
                    chk("if_pc",    bus.if_pc,    e.pc);
                    chk("if_err",   32'(bus.if_err), 32'(e.err));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : driver
        logic [31:0] a, wa;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = c_NOP;
        m_out.ready = 1'b1; m_out.valid = 1'b0; m_out.rdata = c_NOP;
        m_out.pc = '0; m_out.err = 1'b0;
        rst = 1'b1;
        bus.if_req = 0; bus.if_addr = 0; bus.if_stall = 0; bus.if_flush = 0;
        bus.wen = 1; bus.wbe = 0; bus.waddr = 0; bus.wdata = 0;

        repeat (3) cycle(1, 0, 0, 0, 0, 0, 4'h0, 0, 0);
        rd(32'h0); idle();
        wr(32'h10, 32'hDEAD_BEEF, 4'hF);
        wr(32'h10, 32'h0000_00AA, 4'b0001);
        rd(32'h10); idle();
        rd(32'h0);
        cycle(0, 1, 32'h4, 1, 0, 0, 4'h0, 0, 0);
        rd(32'h8); idle();
        rd(32'h6); rd(32'(4 * DEPTH)); idle();
        cycle(0, 1, 32'h20, 0, 0, 1, 4'hF, 32'h20, 32'h1234_5678);
        rd(32'h20); idle();
        rd(32'h0);
        cycle(0, 0, 0, 0, 1, 0, 4'h0, 0, 0);
        rd(32'h4);
        cycle(0, 1, 32'h40, 0, 1, 0, 4'h0, 0, 0);
        cycle(0, 1, 32'h44, 1, 1, 0, 4'h0, 0, 0);
        rd(32'h8);
        cycle(1, 1, 32'hC, 0, 0, 0, 4'h0, 0, 0);
        idle();
        wr(32'(4 * DEPTH + 8), 32'hFFFF_FFFF, 4'hF);
        rd(32'h8);

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 19))
                0:       a = {24'($urandom_range(0, 15)), 6'd0, 2'($urandom_range(1, 3))};
                1:       a = 32'((DEPTH + $urandom_range(0, 15)) * 4);
                default: a = {$urandom_range(0, 15), 2'b00};
            endcase
            wa = ($urandom_range(0, 9) == 0) ? 32'((DEPTH + $urandom_range(0, 15)) * 4)
                                             : {$urandom_range(0, 15), 2'($urandom_range(0, 3))};
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, a,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) == 0, 4'($urandom), wa, $urandom);
        end
        idle();

        @(posedge clk);
        #2;
        done = 1'b1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_sync.md
# imem_sync

Parametrised, synchronous-read instruction memory for the fetch stage, with a single-cycle request/response port and a byte-enable write port for program loading. It replaces the combinational-read instruction store. It adds registered output, stall hold, flush, misalignment and range checks, and configurable depth and width. The block sits between the PC/fetch logic and the IF/ID pipeline register. The loader or debug writer drives the write port.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width.
- `DATA_W`, 32, instruction word width; must be a multiple of 8.
- `DEPTH`, 4096, number of words; must be a power of two.
- `NOP`, 32'h0000_0013, fill word and reset value of read data (`addi x0,x0,0`).

Ports (every port is sampled or updated on the rising edge of `clk`):
- `clk`, input, 1, system clock.
- `rst`, input, 1, reset; synchronous, active-high.
- `if_req`, input, 1, fetch request.
- `if_addr`, input, ADDR_W, fetch byte address.
- `if_stall`, input, 1, consumer cannot take data; hold the output.
- `if_flush`, input, 1, discard the held output (branch redirect).
- `if_ready`, output, 1, request can be accepted; equals `!if_stall`.
- `if_valid`, output, 1, response valid.
- `if_rdata`, output, DATA_W, fetched instruction.
- `if_pc`, output, ADDR_W, address of the returned instruction.
- `if_err`, output, 1, returned fetch was misaligned or out of range.
- `wen`, input, 1, write enable, active-low.
- `wbe`, input, DATA_W/8, byte-lane enables, active-high.
- `waddr`, input, ADDR_W, write byte address.
- `wdata`, input, DATA_W, write data.

## Operation
- Word index is `addr[ADDR_W-1:2]`.
  - `addr[1:0]` is ignored on writes.
  - On reads, `addr[1:0] != 0` is a misalignment.
- Writes: when `wen == 0`, each lane with `wbe[i] == 1` updates byte i of the indexed word at the clock edge.
  - Writes with index `>= DEPTH` are dropped silently.
  - Writes are not gated by `rst`, stall or flush.
- Fetch acceptance: a request is accepted when `if_req && !if_stall`.
  - On an accepted request: `if_valid <= 1`, `if_pc <= if_addr`, and `if_rdata <= mem[idx]`.
  - If the address is misaligned or `idx >= DEPTH`: `if_rdata <= NOP` and `if_err <= 1`. Otherwise `if_err <= 0`.
- No accepted request and `!if_stall`: `if_valid <= 0`. `if_rdata`, `if_pc` and `if_err` hold their values.
- `if_stall == 1`: all outputs hold, and `if_req` is ignored.
- `if_flush == 1`: `if_valid <= 0`, unless a request is accepted in the same cycle, in which case the new request is loaded (redirect wins).
- Flush during stall: `if_valid <= 0`. The stall still blocks acceptance.
- Read-during-write to the same word in the same cycle: behaviour is set by the configuration macro (see below).
- Memory initialisation: every word is set to `NOP` by `initial` (simulation and FPGA init). `rst` does not clear memory.

## Timing
- Read latency is 1 cycle: a request accepted at edge N presents `if_rdata`/`if_pc`/`if_err` and `if_valid=1` after edge N. Back-to-back requests deliver one word per cycle.
- A write at edge N is visible to a read accepted at edge N+1.
- Reset values: `if_valid=0`, `if_rdata=NOP`, `if_pc=0`, `if_err=0`.
- `if_ready` is combinational and equals `!if_stall`, including during `rst`.
- `rst` has priority over req, stall and flush. A request present in the same cycle as `rst` is dropped.
- Reset asserted mid-stream: the output is invalid after one edge, and the pending word is lost.

## Configuration
- `IMEM_BYPASS_EN` defined: a same-cycle write to the fetched word forwards data.
  - `if_rdata` equals the old word with the `wbe` lanes replaced by `wdata`.
- `IMEM_BYPASS_EN` undefined: read-before-write.
  - `if_rdata` returns the old contents.
  - The new value is visible from the next access.

## Structure
- Package `imem_pkg` holds:
  - the `NOP` constant;
  - `INST_W`/`ADDR_W` defaults;
  - a function `word_idx(addr)`;
  - a function `merge_be(old, new, be)`, used for both the write path and the bypass.
- Sub-module `imem_bank` holds the storage array and the byte-enable write, with a combinational read by index.
- The top module holds the handshake registers, the error checks and the bypass mux.

## Test plan
- Reset, then read address 0x0 (nothing written) → next cycle `if_valid=1`, `if_rdata=0x00000013`, `if_pc=0x0`, `if_err=0`.
- Write 0xDEADBEEF to address 0x10 with `wbe=4'hF`, then write `wbe=4'b0001`/wdata 0x000000AA, then read 0x10 → `if_rdata=0xDEADBEAA`.
- Requests to 0x0, 0x4 and 0x8 on consecutive cycles, with `if_stall` high in the cycle after the first request → 0x0 holds for 2 cycles, the 0x4 request issued during the stall is not accepted, and 0x8 is returned after the stall releases.
- Read 0x6, and read `4*DEPTH` → `if_err=1`, `if_rdata=0x00000013`, `if_valid=1`.
- Write 0x12345678 to 0x20 while requesting 0x20 in the same cycle:
  - with `IMEM_BYPASS_EN` → 0x12345678;
  - without it → the old value 0x00000013.
- Flush with no request → `if_valid=0` next cycle.
- Flush together with a request to 0x40 → `if_valid=1`, `if_pc=0x40`.
- Assert `rst` while `if_valid=1` → outputs return to their reset values after one edge.
